// File: rtl/hs_pkg.sv
// hs_pkg: shared definitions for the high-speed serializer transmit controller.
//   HS_WORD_W   : default symbol width (matches the serializer shift register)
//   HS_IDLE_SYM : default fill symbol, used only when HS_TX_IDLE_FILL_EN is defined
//   hs_state_t  : controller FSM states (IDLE, SHIFT)
package hs_pkg;

    localparam int unsigned HS_WORD_W = 10;
    localparam logic [HS_WORD_W-1:0] HS_IDLE_SYM = 10'b0011111010;

    // Legacy encodings kept as named constants; the enum reuses them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } hs_state_t;

endpackage

// File: rtl/hs_bit_timer.sv
// hs_bit_timer: bit-period divider for the serializer controller.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : restart the bit period (asserted on every symbol load)
//   enable     : count this cycle (controller is shifting)
//   tick       : high on the last clk of each bit period; the counter wraps here
module hs_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;

    assign tick = enable && (clk_cnt == LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
        end else if (clear) begin
            clk_cnt <= '0;
        end else if (enable) begin
            clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hs_tx_ctrl.sv
// hs_tx_ctrl: sequencing controller for the high-speed serializer shift register.
// Buffers one upstream symbol and strobes load/shift at CLKS_PER_BIT clocks per bit
// so consecutive symbols leave back-to-back with no gap cycles.
//   clk, n_rst      : clock, asynchronous active-low reset
//   data_in         : upstream symbol
//   data_valid      : data_in is valid
//   data_ready      : holding register empty (transfer on valid && ready)
//   sr_parallel_out : load value for the shift register
//   sr_load_enable  : one-cycle load strobe
//   sr_shift_enable : one-cycle shift strobe
//   word_done       : pulse on the final bit tick of a user symbol
//   busy            : shifting or holding a symbol
// Build option: define HS_TX_IDLE_FILL_EN to transmit IDLE_SYM whenever no user
// symbol is waiting; the line then never goes quiet after reset release.
module hs_tx_ctrl
    import hs_pkg::*;
#(
    parameter int unsigned             WORD_W       = HS_WORD_W,
    parameter int unsigned             CLKS_PER_BIT = 4,
    parameter logic [WORD_W-1:0]       IDLE_SYM     = HS_IDLE_SYM
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [WORD_W-1:0] sr_parallel_out,
    output logic              sr_load_enable,
    output logic              sr_shift_enable,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    hs_state_t         state, state_nxt;
    logic              hold_valid;
    logic [WORD_W-1:0] hold_data;
    logic [BW-1:0]     bit_cnt;
    logic              tick;
    logic              accept;
    logic              consume;
    logic              load;
    logic              shift;
    logic              done;
    logic              cur_user;

    hs_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (load),
        .enable (state == SHIFT),
        .tick   (tick)
    );

    // accept requires an empty hold and consume a full one, so a symbol can
    // never be taken and loaded in the same cycle.
    assign accept = data_valid && !hold_valid;

`ifdef HS_TX_IDLE_FILL_EN
    logic fill_load;
`else
    logic unused_idle_sym;
    assign unused_idle_sym = ^IDLE_SYM;
    assign cur_user        = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        consume   = 1'b0;
`ifdef HS_TX_IDLE_FILL_EN
        fill_load = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load      = 1'b1;
                    consume   = 1'b1;
                    state_nxt = SHIFT;
                end
`ifdef HS_TX_IDLE_FILL_EN
                // IDLE only exists for the first cycle after release; gating
                // on n_rst keeps the strobe low while reset is held.
                else if (n_rst) begin
                    load      = 1'b1;
                    fill_load = 1'b1;
                    state_nxt = SHIFT;
                end
`endif
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        done = cur_user;
                        // Final tick: load the next symbol instead of the last
                        // shift, which is what makes the stream gapless.
                        if (hold_valid) begin
                            load    = 1'b1;
                            consume = 1'b1;
                        end else begin
`ifdef HS_TX_IDLE_FILL_EN
                            load      = 1'b1;
                            fill_load = 1'b1;
`else
                            shift     = 1'b1;
                            state_nxt = IDLE;
`endif
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            bit_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= data_in;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end
            if (load) begin
                bit_cnt <= '0;
            end else if (tick) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

`ifdef HS_TX_IDLE_FILL_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_user <= 1'b0;
        end else if (load) begin
            cur_user <= !fill_load;
        end
    end

    assign sr_parallel_out = fill_load ? IDLE_SYM : hold_data;
    assign busy            = n_rst;
`else
    assign sr_parallel_out = hold_data;
    assign busy            = (state == SHIFT) || hold_valid;
`endif

    assign data_ready      = !hold_valid;
    assign sr_load_enable  = load;
    assign sr_shift_enable = shift;
    assign word_done       = done;

endmodule

// File: tb/tb_hs_tx_ctrl.sv
// tb_hs_tx_ctrl: directed bench for hs_tx_ctrl (WORD_W=10, CLKS_PER_BIT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-derived from the cycle timeline.
module tb_hs_tx_ctrl;

    localparam logic [9:0] IDLE_SYM_TB = 10'b0011111010;

    // Expected {data_ready, load, shift, done, busy}
    localparam logic [4:0] E_RST = 5'b10000;  // idle / reset
    localparam logic [4:0] E_QB  = 5'b10001;  // shifting, hold empty, no strobe
    localparam logic [4:0] E_SB  = 5'b10101;  // shift strobe, hold empty
    localparam logic [4:0] E_LD  = 5'b01001;  // load from IDLE
    localparam logic [4:0] E_Q0  = 5'b00001;  // shifting, hold full, no strobe
    localparam logic [4:0] E_S0  = 5'b00101;  // shift strobe, hold full
    localparam logic [4:0] E_LDD = 5'b01011;  // gapless load on final tick + done
    localparam logic [4:0] E_FIN = 5'b10111;  // final shift + done, then IDLE

    logic       clk;
    logic       n_rst;
    logic [9:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [9:0] sr_parallel_out;
    logic       sr_load_enable;
    logic       sr_shift_enable;
    logic       word_done;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic        rn;
        logic        valid;
        logic [9:0]  din;
        int unsigned rep;
        logic [4:0]  exp;
        logic        chk_par;
        logic [9:0]  par;
    } vec_t;

    vec_t vecs[$];

    hs_tx_ctrl #(
        .WORD_W       (10),
        .CLKS_PER_BIT (4),
        .IDLE_SYM     (IDLE_SYM_TB)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .data_in         (data_in),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .sr_parallel_out (sr_parallel_out),
        .sr_load_enable  (sr_load_enable),
        .sr_shift_enable (sr_shift_enable),
        .word_done       (word_done),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {data_ready, sr_load_enable, sr_shift_enable, word_done, busy};
    endfunction

    function automatic void add(input logic rn, input logic v, input logic [9:0] d,
                                input int unsigned rep, input logic [4:0] exp,
                                input logic cp, input logic [9:0] p);
        vec_t r;
        r.rn = rn; r.valid = v; r.din = d; r.rep = rep;
        r.exp = exp; r.chk_par = cp; r.par = p;
        vecs.push_back(r);
    endfunction

    // n bit periods after a load with no upstream traffic: 3 quiet, 1 shift.
    function automatic void add_bits(input int unsigned n, input logic [4:0] q,
                                     input logic [4:0] s);
        for (int unsigned i = 0; i < n; i++) begin
            add(1'b1, 1'b0, 10'h000, 3, q, 1'b0, 10'h000);
            add(1'b1, 1'b0, 10'h000, 1, s, 1'b0, 10'h000);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [4:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: {rdy,ld,sh,done,busy} got %b expected %b", name, outs(), exp);
        end
    endtask

    task automatic check_par(input string name, input logic [9:0] exp);
        checks++;
        if (sr_parallel_out !== exp) begin
            errors++;
            $display("FAIL %s: sr_parallel_out got %h expected %h", name, sr_parallel_out, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

`ifndef HS_TX_IDLE_FILL_EN
    task automatic run_table();
        foreach (vecs[r]) begin
            for (int unsigned c = 0; c < vecs[r].rep; c++) begin
                n_rst      = vecs[r].rn;
                data_valid = vecs[r].valid;
                data_in    = vecs[r].din;
                @(negedge clk);
                check_outs($sformatf("row%0d.%0d", r, c), vecs[r].exp);
                if (vecs[r].chk_par)
                    check_par($sformatf("row%0d.%0d par", r, c), vecs[r].par);
                next_cycle();
            end
        end
    endtask

    task automatic latency_seq();
        int load_at = -1;
        int done_at = -1;
        int nshift  = 0;
        int both    = 0;
        data_valid = 1'b1;
        data_in    = 10'h155;
        @(negedge clk);
        check_outs("lat accept", E_RST);
        next_cycle();
        data_valid = 1'b0;
        for (int cyc = 1; cyc < 100 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (sr_load_enable && load_at < 0) begin
                load_at = cyc;
                check_par("lat load value", 10'h155);
            end
            if (sr_shift_enable) nshift++;
            if (sr_load_enable && sr_shift_enable) both++;
            if (word_done) done_at = cyc;
            next_cycle();
        end
        if (done_at < 0) begin
            errors++;
            checks++;
            $display("FAIL lat word_done: timeout after 100 cycles, expected at cycle 41");
        end else begin
            check_int("lat word_done cycle", done_at, 41);
        end
        check_int("lat load cycle", load_at, 1);
        check_int("lat shift count", nshift, 10);
        check_int("lat load&shift overlap", both, 0);
        @(negedge clk);
        check_outs("lat idle after", E_RST);
        next_cycle();
    endtask

    task automatic async_reset_seq();
        int loads = 0;
        data_valid = 1'b1;
        data_in    = 10'h2AB;
        next_cycle();
        data_valid = 1'b0;
        @(negedge clk);
        check_outs("arst pre", E_LD);
        #2;
        n_rst = 1'b0;
        #1;
        check_outs("arst immediate", E_RST);
        check_par("arst par", 10'h000);
        next_cycle();
        n_rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sr_load_enable || sr_shift_enable || busy) loads++;
            next_cycle();
        end
        check_int("arst no activity", loads, 0);
    endtask
`else
    task automatic fill_seq();
        logic [4:0] exp;
        n_rst      = 1'b0;
        data_valid = 1'b0;
        data_in    = 10'h000;
        @(negedge clk);
        check_outs("fill reset", E_RST);
        check_par("fill reset par", 10'h000);
        next_cycle();
        n_rst = 1'b1;
        for (int i = 0; i < 126; i++) begin
            data_valid = (i == 5);
            data_in    = (i == 5) ? 10'h0F0 : 10'h3FF;
            @(negedge clk);
            exp[4] = !(i >= 6 && i <= 40);
            exp[3] = (i % 40 == 0);
            exp[2] = (i % 4 == 0) && (i % 40 != 0);
            exp[1] = (i == 80);
            exp[0] = 1'b1;
            check_outs($sformatf("fill cyc%0d", i), exp);
            if (exp[3])
                check_par($sformatf("fill cyc%0d par", i), (i == 40) ? 10'h0F0 : IDLE_SYM_TB);
            next_cycle();
        end
    endtask
`endif

    initial begin
        n_rst      = 1'b0;
        data_valid = 1'b0;
        data_in    = 10'h000;
        next_cycle();
`ifdef HS_TX_IDLE_FILL_EN
        fill_seq();
`else
        // Reset and quiet release
        add(1'b0, 1'b0, 10'h000, 3, E_RST, 1'b1, 10'h000);
        add(1'b1, 1'b0, 10'h000, 20, E_RST, 1'b1, 10'h000);
        // Single symbol
        add(1'b1, 1'b1, 10'h2AB, 1, E_RST, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1, E_LD, 1'b1, 10'h2AB);
        add_bits(9, E_QB, E_SB);
        add(1'b1, 1'b0, 10'h000, 3, E_QB, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1, E_FIN, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 4, E_RST, 1'b0, 10'h000);
        // Back-to-back with backpressure (3FF must never be taken)
        add(1'b1, 1'b1, 10'h2AB, 1, E_RST, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1, E_LD, 1'b1, 10'h2AB);
        add_bits(2, E_QB, E_SB);
        add(1'b1, 1'b1, 10'h154, 1, E_QB, 1'b0, 10'h000);
        add(1'b1, 1'b1, 10'h3FF, 2, E_Q0, 1'b0, 10'h000);
        for (int i = 0; i < 7; i++) begin
            add(1'b1, 1'b1, 10'h3FF, 1, E_S0, 1'b0, 10'h000);
            add(1'b1, 1'b1, 10'h3FF, 3, E_Q0, 1'b0, 10'h000);
        end
        add(1'b1, 1'b1, 10'h3FF, 1, E_LDD, 1'b1, 10'h154);
        add(1'b1, 1'b1, 10'h0AA, 1, E_QB, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 2, E_Q0, 1'b0, 10'h000);
        for (int i = 0; i < 9; i++) begin
            add(1'b1, 1'b0, 10'h000, 1, E_S0, 1'b0, 10'h000);
            add(1'b1, 1'b0, 10'h000, 3, E_Q0, 1'b0, 10'h000);
        end
        add(1'b1, 1'b0, 10'h000, 1, E_LDD, 1'b1, 10'h0AA);
        add_bits(9, E_QB, E_SB);
        add(1'b1, 1'b0, 10'h000, 3, E_QB, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1, E_FIN, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 3, E_RST, 1'b0, 10'h000);
        // Reset mid-symbol, then no load without a new accept
        add(1'b1, 1'b1, 10'h2AB, 1, E_RST, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1, E_LD, 1'b1, 10'h2AB);
        add_bits(4, E_QB, E_SB);
        add(1'b1, 1'b0, 10'h000, 2, E_QB, 1'b0, 10'h000);
        add(1'b0, 1'b0, 10'h000, 2, E_RST, 1'b1, 10'h000);
        add(1'b1, 1'b0, 10'h000, 12, E_RST, 1'b1, 10'h000);
        run_table();
        latency_seq();
        async_reset_seq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_tx_ctrl.md
Name: hs_tx_ctrl

Overview:
- Sequencing controller for the 10-bit high-speed serializer shift register.
- Accepts parallel symbols from upstream over a valid/ready handshake and buffers one symbol in a holding register.
- Drives the shift register's load and shift strobes at a programmable bit rate so consecutive symbols go out back-to-back with no gap cycles.
- Sits between the symbol encoder and the serializer shift register.

Parameters:
- WORD_W, 10: symbol width in bits; must match the shift register width.
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal range 1..256.
- IDLE_SYM, 10'b0011111010: fill symbol; used only with HS_TX_IDLE_FILL_EN.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- data_in  input  WORD_W  upstream symbol.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  holding register empty; a transfer occurs when valid && ready.
- sr_parallel_out  output  WORD_W  load value to the shift register.
- sr_load_enable  output  1  one-cycle load strobe.
- sr_shift_enable  output  1  one-cycle shift strobe.
- word_done  output  1  one-cycle pulse on the final bit tick of a user symbol.
- busy  output  1  high while shifting or while a symbol is held.

Behaviour:
- Reset, asynchronous and legal at any time including mid-symbol:
  - Reset values: state=IDLE, counters=0, hold_valid=0, hold_data=0.
  - Outputs during reset: sr_load_enable=0, sr_shift_enable=0, word_done=0, busy=0, sr_parallel_out=0, data_ready=1.
  - Any held symbol is discarded.
- Handshake:
  - data_ready = !hold_valid.
  - On valid && ready, hold_data<=data_in and hold_valid<=1. Accepts are allowed in any state.
  - A symbol is never accepted and consumed in the same cycle.
- Load value: sr_parallel_out is driven from hold_data (fill mode excepted, see Optional Feature).
- Strobe rule: sr_load_enable and sr_shift_enable are mutually exclusive in every cycle.
- State IDLE:
  - If hold_valid: sr_load_enable=1 (load cycle L), hold_valid<=0, clk_cnt<=0, bit_cnt<=0, next state SHIFT.
  - Otherwise remain in IDLE.
- State SHIFT:
  - clk_cnt increments every cycle; a tick occurs when clk_cnt==CLKS_PER_BIT-1, and clk_cnt wraps to 0 on the tick.
  - Ticks fall at L+k*CLKS_PER_BIT for k=1..WORD_W.
  - Non-final tick (bit_cnt<WORD_W-1): sr_shift_enable=1, bit_cnt++.
  - Final tick (bit_cnt==WORD_W-1), word_done=1 if the current symbol is a user symbol:
    - hold_valid=1: sr_load_enable=1 (no shift), hold consumed, counters reset to 0, stay in SHIFT. The next symbol follows with zero gap.
    - hold_valid=0: sr_shift_enable=1, next state IDLE.
- busy = (state==SHIFT) || hold_valid.
- Latency: accept at cycle t, load at t+1, first bit visible on serial output at t+2.
- Counter widths: $clog2(CLKS_PER_BIT) and $clog2(WORD_W), each minimum 1 bit.
- CLKS_PER_BIT=1 gives a tick every SHIFT cycle.

Optional Feature:
- Macro: HS_TX_IDLE_FILL_EN.
- Defined:
  - The controller never enters IDLE after reset. On the first cycle after reset release it loads IDLE_SYM and enters SHIFT.
  - On any final tick with hold_valid=0, it loads IDLE_SYM instead of shifting.
  - sr_parallel_out carries IDLE_SYM on fill loads.
  - A cur_user flag tracks symbol type; word_done pulses only for user symbols.
  - busy=1 continuously after reset release.
- Undefined: behaviour exactly as above; IDLE_SYM is unused.

Decomposition:
- Package hs_pkg: state enum (IDLE, SHIFT), WORD_W default, IDLE_SYM default.
- Sub-module hs_bit_timer: clk_cnt divider with clear input and tick output. The FSM, holding register and bit counter remain in hs_tx_ctrl.

Test Plan:
- Reset check: n_rst=0 -> data_ready=1, all strobes 0, busy=0; release with no valid -> outputs stay idle indefinitely.
- Single symbol, CLKS_PER_BIT=4: accept 10'h2AB at t -> load at t+1 with sr_parallel_out=10'h2AB; shifts at t+5,t+9,...,t+41 (10 strobes); word_done at t+41; busy=0 at t+42.
- Back-to-back: 10'h2AB then 10'h154 accepted at t+10 -> data_ready=0 from t+11 to t+41; at t+41 load 10'h154 with no shift strobe; next shifts at t+45...; no gap cycle.
- Backpressure: hold data_valid=1 with changing data_in while hold full -> data_in ignored until data_ready returns; the accepted value is the one present on the ready cycle.
- Reset mid-symbol: assert n_rst at t+20 -> all outputs return to reset values immediately; after release no load occurs without a new accept.
- HS_TX_IDLE_FILL_EN: release reset with no data -> load IDLE_SYM every 40 cycles, word_done never pulses; inject 10'h0F0 -> loaded at the next final tick, word_done at its final tick, then fill resumes.
